// File: rtl/plic_claim_agent.sv
// -----------------------------------------------------------------------------
// plic_claim_agent
//
// Purpose: hart-side claim/complete agent for one interrupt-controller target.
// On irq_i it reads (TL-UL Get) the target's claim/complete register. A non-zero
// ID is handed to a local handler over id_valid_o/id_ready_i. The agent then
// waits for done_i and writes the ID back (PutFullData) to complete the
// interrupt.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   irq_i             target interrupt request (level)
//   tl_o / tl_i       TL-UL host request + d_ready / device response + a_ready
//   id_valid_o, id_o  claimed source ID offered to the handler
//   id_ready_i        handler accepts the ID
//   done_i            handler finished (single-cycle pulse, used in SERVICE only)
//   busy_o            agent not idle
//   err_o             one-cycle pulse on D-channel error (or response timeout)
//   spurious_o        one-cycle pulse when the claim returns ID 0
//
// Optional feature: define PLIC_CLAIM_AGENT_TIMEOUT_EN to add a TimeoutW-bit
// D-channel watchdog in the response states.
// -----------------------------------------------------------------------------
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [7:0] TL_A_USER_DEFAULT = 8'h00;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [7:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module plic_claim_agent
  import tlul_pkg::*;
#(
  parameter logic [31:0] CcAddr   = 32'h0C20_0004,
  parameter int unsigned SrcW     = 6,
  parameter logic [7:0]  SourceId = 8'd0,
  parameter int unsigned TimeoutW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            irq_i,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i,
  output logic            id_valid_o,
  output logic [SrcW-1:0] id_o,
  input  logic            id_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o,
  output logic            spurious_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLM_REQ  = 3'd1;
  localparam logic [2:0] ST_CLM_RSP  = 3'd2;
  localparam logic [2:0] ST_DISPATCH = 3'd3;
  localparam logic [2:0] ST_SERVICE  = 3'd4;
  localparam logic [2:0] ST_CMP_REQ  = 3'd5;
  localparam logic [2:0] ST_CMP_RSP  = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [SrcW-1:0] id_q, id_d;
  logic            busy_q;
  logic            err_pulse, spur_pulse;
  logic            tmo_hit;

`ifdef PLIC_CLAIM_AGENT_TIMEOUT_EN
  // Fires in the cycle whose increment would make the counter all-ones.
  localparam logic [TimeoutW-1:0] TmoLast = {{(TimeoutW-1){1'b1}}, 1'b0};
  logic [TimeoutW-1:0] tmo_q, tmo_d;
  logic                in_rsp;

  assign in_rsp  = (state_q == ST_CLM_RSP) || (state_q == ST_CMP_RSP);
  assign tmo_hit = in_rsp && !tl_i.d_valid && (tmo_q == TmoLast);
  // Counter only runs while remaining in a response state; any exit or
  // non-response state forces it back to zero so each entry starts fresh.
  assign tmo_d   = (in_rsp && (state_d == state_q)) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [TimeoutW-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign tmo_hit          = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    err_pulse  = 1'b0;
    spur_pulse = 1'b0;
    case (state_q)
      ST_IDLE:     if (irq_i) state_d = ST_CLM_REQ;
      ST_CLM_REQ:  if (tl_i.a_ready) state_d = ST_CLM_RSP;
      ST_CLM_RSP: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            err_pulse = 1'b1;
            state_d   = ST_IDLE;
          end else if (tl_i.d_data[SrcW-1:0] == '0) begin
            spur_pulse = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            id_d    = tl_i.d_data[SrcW-1:0];
            state_d = ST_DISPATCH;
          end
        end else if (tmo_hit) begin
          err_pulse = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      // done_i is deliberately not looked at here: a done coinciding with the
      // ID handshake belongs to no service yet.
      ST_DISPATCH: if (id_ready_i) state_d = ST_SERVICE;
      ST_SERVICE:  if (done_i) state_d = ST_CMP_REQ;
      ST_CMP_REQ:  if (tl_i.a_ready) state_d = ST_CMP_RSP;
      ST_CMP_RSP: begin
        if (tl_i.d_valid) begin
          err_pulse = tl_i.d_error;
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          err_pulse = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // A-channel fields are constant except opcode/data, so they stay stable
  // for as long as a request waits on a_ready.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == ST_CLM_REQ) || (state_q == ST_CMP_REQ);
    tl_o.a_opcode  = (state_q == ST_CMP_REQ) ? PutFullData : Get;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = CcAddr;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = (state_q == ST_CMP_REQ) ? {{(32-SrcW){1'b0}}, id_q} : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = (state_q == ST_CLM_RSP) || (state_q == ST_CMP_RSP);
  end

  assign id_valid_o = (state_q == ST_DISPATCH);
  assign id_o       = id_q;
  assign busy_o     = busy_q;
  assign err_o      = err_pulse;
  assign spurious_o = spur_pulse;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_data[31:SrcW], tl_i.d_user};

endmodule

// File: tb/tb_plic_claim_agent.sv
// -----------------------------------------------------------------------------
// tb_plic_claim_agent: directed vectors for plic_claim_agent. The bench plays
// the TL-UL device and the local handler by hand; a small monitor counts Gets
// and Puts and records Put data.
// -----------------------------------------------------------------------------
module tb_plic_claim_agent;
  import tlul_pkg::*;

  localparam logic [31:0] CC = 32'h0C20_0004;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq = 1'b0;
  tl_h2d_t    tl_o;
  tl_d2h_t    tl_i;
  logic       id_valid;
  logic [5:0] id;
  logic       id_ready = 1'b0;
  logic       done = 1'b0;
  logic       busy, err, spur;

  int n_vec  = 0;
  int n_miss = 0;
  int n_get  = 0;
  int n_put  = 0;
  logic [31:0] put_data[$];

  always #5 clk = ~clk;

  plic_claim_agent #(.CcAddr(CC), .SrcW(6), .SourceId(8'd0), .TimeoutW(4)) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq), .tl_o(tl_o), .tl_i(tl_i),
    .id_valid_o(id_valid), .id_o(id), .id_ready_i(id_ready), .done_i(done),
    .busy_o(busy), .err_o(err), .spurious_o(spur)
  );

  always @(posedge clk) begin
    if (!rst && tl_o.a_valid && tl_i.a_ready) begin
      if (tl_o.a_opcode == Get) n_get <= n_get + 1;
      else begin
        n_put <= n_put + 1;
        put_data.push_back(tl_o.a_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one D beat for one cycle.
  task automatic d_beat(input logic [31:0] data, input logic e);
    tl_i.d_valid = 1'b1;
    tl_i.d_data  = data;
    tl_i.d_error = e;
  endtask

  task automatic d_clear();
    tl_i.d_valid = 1'b0;
    tl_i.d_data  = 32'h0;
    tl_i.d_error = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".a_valid"}, 32'(tl_o.a_valid), 32'd0);
    chk({tag, ".d_ready"}, 32'(tl_o.d_ready), 32'd0);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Drive a claim that returns rsp_id and take it up to SERVICE.
  task automatic claim_to_service(input logic [5:0] rsp_id);
    irq = 1'b1; tl_i.a_ready = 1'b1;
    step();                       // CLM_REQ
    irq = 1'b0;
    step();                       // CLM_RSP
    tl_i.a_ready = 1'b0;
    d_beat({26'h0, rsp_id}, 1'b0);
    step();                       // DISPATCH
    d_clear();
    id_ready = 1'b1;
    step();                       // SERVICE
    id_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, p0;
    tl_i = '0;

    // Reset state
    step(); step();
    chk_idle("reset");
    chk("reset.id", 32'(id), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.spur", 32'(spur), 32'd0);
    rst = 1'b0;
    step();

    // Basic flow with ID 5
    irq = 1'b1; tl_i.a_ready = 1'b1;
    step();
    irq = 1'b0;
    chk("basic.get_valid", 32'(tl_o.a_valid), 32'd1);
    chk("basic.get_op", 32'(tl_o.a_opcode), 32'd4);
    chk("basic.get_addr", tl_o.a_address, CC);
    chk("basic.get_size", 32'(tl_o.a_size), 32'd2);
    chk("basic.get_mask", 32'(tl_o.a_mask), 32'hF);
    chk("basic.get_data", tl_o.a_data, 32'd0);
    chk("basic.busy", 32'(busy), 32'd1);
    chk("basic.no_dready", 32'(tl_o.d_ready), 32'd0);
    step();
    tl_i.a_ready = 1'b0;
    chk("basic.rsp_dready", 32'(tl_o.d_ready), 32'd1);
    chk("basic.rsp_avalid", 32'(tl_o.a_valid), 32'd0);
    d_beat(32'd5, 1'b0);
    step();
    d_clear();
    chk("basic.id_valid", 32'(id_valid), 32'd1);
    chk("basic.id", 32'(id), 32'd5);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("basic.svc_id_valid", 32'(id_valid), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("basic.put_valid", 32'(tl_o.a_valid), 32'd1);
    chk("basic.put_op", 32'(tl_o.a_opcode), 32'd0);
    chk("basic.put_data", tl_o.a_data, 32'd5);
    chk("basic.put_addr", tl_o.a_address, CC);
    tl_i.a_ready = 1'b1;
    step();
    tl_i.a_ready = 1'b0;
    chk("basic.cmp_dready", 32'(tl_o.d_ready), 32'd1);
    d_beat(32'd0, 1'b0);
    step();
    d_clear();
    chk_idle("basic.end");
    chk("basic.n_get", 32'(n_get), 32'd1);
    chk("basic.n_put", 32'(n_put), 32'd1);
    chk("basic.put_q", put_data[0], 32'd5);

    // Spurious claim: low six bits zero, upper bits set
    p0 = n_put;
    irq = 1'b1; tl_i.a_ready = 1'b1;
    step();
    irq = 1'b0;
    step();
    tl_i.a_ready = 1'b0;
    d_beat(32'h0000_0040, 1'b0);
    #1;
    chk("spur.pulse", 32'(spur), 32'd1);
    chk("spur.no_err", 32'(err), 32'd0);
    step();
    d_clear();
    chk("spur.pulse_end", 32'(spur), 32'd0);
    chk_idle("spur.end");
    step(); step();
    chk("spur.still_idle", 32'(id_valid), 32'd0);
    chk("spur.no_put", 32'(n_put), 32'(p0));

    // Backpressure: a_ready low 4 cycles, id_ready low 6 cycles, ID 17
    g0 = n_get; p0 = n_put;
    irq = 1'b1;
    step();
    irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp.get_hold_valid", 32'(tl_o.a_valid), 32'd1);
      chk("bp.get_hold_op", 32'(tl_o.a_opcode), 32'd4);
      chk("bp.get_hold_addr", tl_o.a_address, CC);
      step();
    end
    tl_i.a_ready = 1'b1;
    step();
    tl_i.a_ready = 1'b0;
    d_beat(32'd17, 1'b0);
    step();
    d_clear();
    for (int i = 0; i < 6; i++) begin
      chk("bp.id_hold_valid", 32'(id_valid), 32'd1);
      chk("bp.id_hold", 32'(id), 32'd17);
      step();
    end
    // done coinciding with the ID handshake must be ignored
    id_ready = 1'b1; done = 1'b1;
    step();
    id_ready = 1'b0; done = 1'b0;
    step(); step();
    chk("bp.done_ignored", 32'(tl_o.a_valid), 32'd0);
    chk("bp.svc_busy", 32'(busy), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp.put_hold_op", 32'(tl_o.a_opcode), 32'd0);
      chk("bp.put_hold_data", tl_o.a_data, 32'd17);
      step();
    end
    tl_i.a_ready = 1'b1;
    step();
    tl_i.a_ready = 1'b0;
    d_beat(32'd0, 1'b0);
    step();
    d_clear();
    chk("bp.one_get", 32'(n_get - g0), 32'd1);
    chk("bp.one_put", 32'(n_put - p0), 32'd1);
    chk_idle("bp.end");

    // Bus error on claim
    irq = 1'b1; tl_i.a_ready = 1'b1;
    step();
    irq = 1'b0;
    step();
    tl_i.a_ready = 1'b0;
    d_beat(32'd7, 1'b1);
    #1;
    chk("berr_clm.err", 32'(err), 32'd1);
    step();
    d_clear();
    chk("berr_clm.err_end", 32'(err), 32'd0);
    chk_idle("berr_clm.end");

    // Bus error on complete (ID 8)
    claim_to_service(6'd8);
    done = 1'b1;
    step();
    done = 1'b0;
    tl_i.a_ready = 1'b1;
    step();
    tl_i.a_ready = 1'b0;
    d_beat(32'd0, 1'b1);
    #1;
    chk("berr_cmp.err", 32'(err), 32'd1);
    step();
    d_clear();
    chk("berr_cmp.err_end", 32'(err), 32'd0);
    chk_idle("berr_cmp.end");

    // Back-to-back: irq held high, IDs 3 then 9
    p0 = n_put;
    irq = 1'b1; tl_i.a_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();                                 // CLM_REQ
      chk("b2b.get_op", 32'(tl_o.a_opcode), 32'd4);
      chk("b2b.get_valid", 32'(tl_o.a_valid), 32'd1);
      if (k == 1) irq = 1'b0;
      step();                                 // CLM_RSP
      d_beat((k == 0) ? 32'd3 : 32'd9, 1'b0);
      step();                                 // DISPATCH
      d_clear();
      chk("b2b.id", 32'(id), (k == 0) ? 32'd3 : 32'd9);
      id_ready = 1'b1;
      step();                                 // SERVICE
      id_ready = 1'b0;
      done = 1'b1;
      step();                                 // CMP_REQ
      done = 1'b0;
      step();                                 // CMP_RSP
      d_beat(32'd0, 1'b0);
      step();                                 // IDLE
      d_clear();
      chk("b2b.idle_busy", 32'(busy), 32'd0);
    end
    tl_i.a_ready = 1'b0;
    step();
    chk_idle("b2b.end");
    chk("b2b.n_put", 32'(n_put - p0), 32'd2);
    chk("b2b.put0", put_data[p0], 32'd3);
    chk("b2b.put1", put_data[p0 + 1], 32'd9);

    // Reset during SERVICE with ID 12
    p0 = n_put;
    claim_to_service(6'd12);
    chk("rst_svc.id_before", 32'(id), 32'd12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_svc");
    chk("rst_svc.id", 32'(id), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("rst_svc.no_put_valid", 32'(tl_o.a_valid), 32'd0);
    chk("rst_svc.no_put", 32'(n_put), 32'(p0));

`ifdef PLIC_CLAIM_AGENT_TIMEOUT_EN
    // Withheld D response: err_o on the 15th CLM_RSP cycle (TimeoutW=4)
    irq = 1'b1; tl_i.a_ready = 1'b1;
    step();
    irq = 1'b0;
    step();                                   // CLM_RSP cycle 1
    tl_i.a_ready = 1'b0;
    for (int c = 1; c < 15; c++) begin
      chk("tmo.quiet", 32'(err), 32'd0);
      chk("tmo.waiting", 32'(tl_o.d_ready), 32'd1);
      step();
    end
    chk("tmo.err", 32'(err), 32'd1);
    step();
    chk("tmo.err_end", 32'(err), 32'd0);
    chk_idle("tmo.end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/plic_claim_agent.md
Name: plic_claim_agent

Overview:
- Hart-side counterpart to the platform interrupt controller: a TL-UL host that services one interrupt target.
- On target IRQ assertion it issues a TL-UL Get to the target's claim/complete (CC) register and captures the returned source ID.
- It hands the ID to a local handler (core shim or accelerator) over a valid/ready pair, waits for the handler's done, then writes the ID back to CC as PutFullData to complete.
- Sits between the interrupt controller's irq/CC interface and a non-CPU interrupt consumer.

Parameters:
- CcAddr, 32'h0C20_0004, byte address of the target's CC register.
- SrcW, 6, width of source ID (includes ID 0 = none).
- SourceId, 0, a_source value driven on all requests.
- TimeoutW, 8, width of D-channel response watchdog counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- irq_i  in  1  target interrupt request (level) from controller.
- tl_o  out  tlul_pkg::tl_h2d_t  TL-UL host request (A) / d_ready.
- tl_i  in  tlul_pkg::tl_d2h_t  TL-UL device response (D) / a_ready.
- id_valid_o  out  1  claimed ID presented to handler.
- id_o  out  SrcW  claimed source ID.
- id_ready_i  in  1  handler accepts ID.
- done_i  in  1  handler finished servicing (single-cycle pulse).
- busy_o  out  1  agent not in IDLE.
- err_o  out  1  one-cycle pulse on bus error or timeout.
- spurious_o  out  1  one-cycle pulse when claim returns ID 0.

Behaviour:
- Reset (rst_i=1 at posedge): state=IDLE; a_valid=0, d_ready=0, id_valid_o=0, id_o=0, busy_o=0, err_o=0, spurious_o=0, captured ID=0. Reset mid-transaction abandons it; the outstanding D beat after reset is ignored (d_ready=0 in IDLE), with no resynchronisation.
- A-channel constants: a_size=2, a_mask=4'hF, a_address=CcAddr, a_source=SourceId, a_param=0, a_user=default. a_data=0 for Get; a_data={zero-ext, ID} for Put.
- States:
  - IDLE: if irq_i=1 -> CLM_REQ next cycle.
  - CLM_REQ: a_valid=1, a_opcode=Get (4). Hold all A fields stable until a_ready=1; on handshake -> CLM_RSP.
  - CLM_RSP: d_ready=1. On d_valid:
    - d_error=1 -> err_o pulse -> IDLE.
    - d_data[SrcW-1:0]==0 -> spurious_o pulse -> IDLE.
    - otherwise latch ID -> DISPATCH.
  - DISPATCH: id_valid_o=1, id_o=latched ID, stable until id_ready_i=1 -> SERVICE.
  - SERVICE: wait for done_i=1 -> CMP_REQ. done_i outside SERVICE is ignored.
  - CMP_REQ: a_valid=1, a_opcode=PutFullData (0), a_data=ID; on a_ready -> CMP_RSP.
  - CMP_RSP: d_ready=1. On d_valid -> IDLE; d_error=1 also pulses err_o.
- Latency: irq_i high in IDLE -> a_valid high on the next cycle. With a_ready=1 and a same-cycle-next D response, id_valid_o rises 3 cycles after irq_i is sampled.
- Only one outstanding transaction; a_valid and d_ready are never both 1.
- irq_i is ignored outside IDLE. If irq_i is still high on return to IDLE, a new claim starts the next cycle (back-to-back servicing).
- If irq_i deasserts after CLM_REQ has started, the request still completes; the controller resolves the race by returning ID 0, which the agent handles as spurious.
- id_ready_i and done_i asserted in the same cycle in DISPATCH: done_i is ignored and SERVICE must see a fresh done_i.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro PLIC_CLAIM_AGENT_TIMEOUT_EN.
- When defined:
  - In CLM_RSP/CMP_RSP a TimeoutW-bit counter clears on state entry and increments each cycle without d_valid.
  - On reaching all-ones: err_o pulse, -> IDLE; any late D beat is dropped (d_ready=0).
  - The counter is held at 0 in all other states.
- When undefined: no counter; the agent waits indefinitely for the D response.

Test Plan:
- Basic flow: irq_i=1, device returns d_data=5 -> Get at CcAddr, then id_valid_o=1 with id_o=5; after id_ready_i and done_i, PutFullData at CcAddr with a_data=5; returns to IDLE with busy_o=0.
- Spurious claim: claim returns d_data=0 -> spurious_o pulses once, id_valid_o never rises, no Put issued, IDLE next cycle.
- Backpressure: a_ready=0 for 4 cycles, then id_ready_i=0 for 6 cycles -> a_valid, opcode, address held stable throughout; id_o=ID 17 held stable; exactly one Get and one Put observed.
- Bus error: d_error=1 on claim -> err_o one pulse, no dispatch. d_error=1 on complete -> err_o pulse, still returns to IDLE.
- Back-to-back IRQs: irq_i held high across two services returning IDs 3 then 9 -> second Get issued on the cycle after CMP_RSP completes; Puts carry 3 then 9 in order.
- Reset mid-SERVICE with ID 12 -> all outputs 0 next cycle, no Put issued. With PLIC_CLAIM_AGENT_TIMEOUT_EN and TimeoutW=4, withhold d_valid -> err_o pulses on the 15th cycle in CLM_RSP.
